// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares one combinational ALU between NUM_REQ requesters.
// Optional feature macro: ALU_OPCHK_EN (illegal ops 1010..1111 answered with rsp_err, skipping the ALU).
module alu_share_ctrl #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2,
    parameter int IDW     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_rs1,
    input  logic [NUM_REQ*XLEN-1:0] req_rs2,
    input  logic [NUM_REQ*4-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]         rsp_data,
    output logic                    rsp_zero,
    output logic                    rsp_err,
    output logic [XLEN-1:0]         alu_rs1,
    output logic [XLEN-1:0]         alu_rs2,
    output logic [3:0]              alu_op,
    input  logic [XLEN-1:0]         alu_rd,
    input  logic                    alu_zero,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id
);

`ifdef ALU_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic            found;
    logic [IDW-1:0]  winner;
    int              best_dist;
    int              cur_dist;
    logic [XLEN-1:0] sel_rs1;
    logic [XLEN-1:0] sel_rs2;
    logic [3:0]      sel_op;
    logic            illegal;
    logic            rsp_accept;

    // Distance 0 is the requester just after rr_ptr; the last-served one is farthest.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        best_dist = NUM_REQ;
        cur_dist  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_dist = (i + NUM_REQ - 1 - int'(rr_ptr)) % NUM_REQ;
            if (req_valid[i] && (cur_dist < best_dist)) begin
                best_dist = cur_dist;
                found     = 1'b1;
                winner    = IDW'(i);
            end
        end
    end

    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        sel_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner) == i) begin
                sel_rs1 = req_rs1[i*XLEN +: XLEN];
                sel_rs2 = req_rs2[i*XLEN +: XLEN];
                sel_op  = req_op[i*4 +: 4];
            end
        end
        illegal = OPCHK && (sel_op > 4'd9);
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_accept = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (state == IDLE) && found && (int'(winner) == i);
            rsp_valid[i] = (state == RESP) && (int'(grant_id) == i);
            if (rsp_valid[i] && rsp_ready[i]) begin
                rsp_accept = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            grant_id <= '0;
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_op   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        rr_ptr   <= winner;
                        if (illegal) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                            rsp_zero <= 1'b1;
                            state    <= RESP;
                        end else begin
                            alu_rs1 <= sel_rs1;
                            alu_rs2 <= sel_rs2;
                            alu_op  <= sel_op;
                            rsp_err <= 1'b0;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data <= alu_rd;
                    rsp_zero <= alu_zero;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, latency and ALU results.
module tb_alu_share_ctrl;

    localparam int XLEN = 32;
    localparam int N    = 3;
    localparam int IDW  = 3;
    localparam int IW   = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*XLEN-1:0] req_rs1;
    logic [N*XLEN-1:0] req_rs2;
    logic [N*4-1:0]    req_op;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic [XLEN-1:0]   alu_rs1;
    logic [XLEN-1:0]   alu_rs2;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   alu_rd;
    logic              alu_zero;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    always #5 clk = ~clk;

    alu_share_ctrl #(.XLEN(XLEN), .NUM_REQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
        .alu_rd(alu_rd), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return {31'b0, $signed(a) < $signed(b)};
            4'd9: return {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        alu_rd   = alu_fn(alu_op, alu_rs1, alu_rs2);
        alu_zero = (alu_rd == 32'h0);
    end

    function automatic bit is_illegal(input logic [3:0] op);
`ifdef ALU_OPCHK_EN
        return op > 4'd9;
`else
        return (op > 4'd9) && 1'b0;
`endif
    endfunction

    bit            pend [N];
    logic [3:0]    p_op [N];
    logic [31:0]   p_a  [N];
    logic [31:0]   p_b  [N];
    logic [N-1:0]  rdy_vec;
    logic [IW-1:0] rr_last;
    logic [IW-1:0] owner;
    bit            inflight;
    int            wait_cnt;
    logic [31:0]   e_data;
    bit            e_zero;
    bit            e_err;
    int            grants[$];
    int            total = 0;
    int            bad = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1;
        p_op[i] = op;
        p_a[i]  = a;
        p_b[i]  = b;
    endtask

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pend[i];
            req_rs1[i*XLEN +: XLEN] = p_a[i];
            req_rs2[i*XLEN +: XLEN] = p_b[i];
            req_op[i*4 +: 4]        = p_op[i];
        end
        rsp_ready = rdy_vec;
    endtask

    // One clock cycle: drive at negedge, check against the model, advance the model after the edge.
    task automatic applyStimulus();
        logic [N-1:0]  exp_ready;
        logic [IW-1:0] w;
        bit            got_w;
        bit            rsp_done;
        exp_ready = '0;
        w         = '0;
        got_w     = 1'b0;
        rsp_done  = 1'b0;
        driveInputs();
        #1;
        checkOutput("busy", 64'(busy), 64'(inflight));
        if (!inflight) begin
            for (int k = 1; k <= N; k++) begin
                logic [IW-1:0] idx;
                idx = IW'((int'(rr_last) + k) % N);
                if (!got_w && pend[idx]) begin
                    got_w = 1'b1;
                    w     = idx;
                end
            end
            if (got_w) exp_ready = N'(1) << w;
            checkOutput("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        end else begin
            if (wait_cnt > 0) wait_cnt--;
            if (wait_cnt > 0) begin
                checkOutput("rsp_valid_early", 64'(rsp_valid), 64'(0));
            end else begin
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(N'(1) << owner));
                checkOutput("rsp_data", 64'(rsp_data), 64'(e_data));
                checkOutput("rsp_zero", 64'(rsp_zero), 64'(e_zero));
                checkOutput("rsp_err", 64'(rsp_err), 64'(e_err));
                checkOutput("grant_id", 64'(grant_id), 64'(owner));
                rsp_done = rdy_vec[owner];
            end
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (rsp_done) inflight = 1'b0;
        if (got_w) begin
            pend[w]  = 1'b0;
            rr_last  = w;
            owner    = w;
            inflight = 1'b1;
            grants.push_back(int'(w));
            if (is_illegal(p_op[w])) begin
                wait_cnt = 1;
                e_data   = 32'h0;
                e_zero   = 1'b1;
                e_err    = 1'b1;
            end else begin
                wait_cnt = 2;
                e_data   = alu_fn(p_op[w], p_a[w], p_b[w]);
                e_zero   = (e_data == 32'h0);
                e_err    = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rdy_vec = '1;
        driveInputs();
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("rst_rsp_zero", 64'(rsp_zero), 64'(0));
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'(0));
        checkOutput("rst_alu_rs1", 64'(alu_rs1), 64'(0));
        checkOutput("rst_alu_rs2", 64'(alu_rs2), 64'(0));
        checkOutput("rst_alu_op", 64'(alu_op), 64'(0));
        checkOutput("rst_grant_id", 64'(grant_id), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        inflight = 1'b0;
        wait_cnt = 0;
        rr_last  = IW'(N - 1);
        grants.delete();
    endtask

    task automatic drain();
        bit any;
        rdy_vec = '1;
        for (int c = 0; c < 40; c++) begin
            any = inflight;
            for (int i = 0; i < N; i++) any = any | pend[i];
            if (any) applyStimulus();
        end
        checkOutput("drain_idle", 64'(inflight), 64'(0));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
        end
        rdy_vec = '1;
        owner   = '0;
        e_data  = '0; e_zero = 1'b0; e_err = 1'b0;
        resetDut();

        // Single add from requester 0.
        setReq(0, 4'd0, 32'h5, 32'h3);
        applyStimulus();
        applyStimulus();
        checkOutput("tp1_valid", 64'(rsp_valid), 64'(3'b001));
        checkOutput("tp1_data", 64'(rsp_data), 64'h8);
        checkOutput("tp1_zero", 64'(rsp_zero), 64'(0));
        drain();

        // Two requesters contending continuously with subtracts.
        resetDut();
        for (int c = 0; c < 12; c++) begin
            if (!pend[0]) setReq(0, 4'd1, 32'h7, 32'h7);
            if (!pend[1]) setReq(1, 4'd1, 32'h9, 32'h4);
            applyStimulus();
        end
        checkOutput("tp2_n_grants", 64'(grants.size()), 64'(4));
        for (int g = 0; g < 4; g++) checkOutput("tp2_order", 64'(grants[g]), 64'(g % 2));
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drain();

        // Response back-pressure, then wrong-index ready.
        resetDut();
        rdy_vec = '0;
        setReq(1, 4'd8, 32'hFFFF_FFFF, 32'h1);
        applyStimulus();
        setReq(0, 4'd0, 32'h1, 32'h2);
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
            checkOutput("tp3_hold", 64'(rsp_data), 64'h1);
            checkOutput("tp3_ready0", 64'(req_ready), 64'(0));
        end
        rdy_vec = 3'b001;
        applyStimulus();
        applyStimulus();
        checkOutput("tp6_wrong_idx", 64'(rsp_valid), 64'(3'b010));
        rdy_vec = '1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp3_next_grant", 64'(grant_id), 64'(0));
        drain();

        // Reset during EXEC of an SRA.
        resetDut();
        setReq(0, 4'd7, 32'h8000_0000, 32'h4);
        applyStimulus();
        checkOutput("tp4_exec_rs1", 64'(alu_rs1), 64'h8000_0000);
        resetDut();
        setReq(1, 4'd2, 32'hF0, 32'h3C);
        setReq(0, 4'd3, 32'hF0, 32'h0F);
        applyStimulus();
        checkOutput("tp4_first_win", 64'(grant_id), 64'(0));
        drain();

        // Undefined op from requester 1.
        resetDut();
        rdy_vec = '0;
        setReq(1, 4'd12, 32'h1234, 32'h5678);
        applyStimulus();
`ifdef ALU_OPCHK_EN
        checkOutput("tp5_valid", 64'(rsp_valid), 64'(3'b010));
        checkOutput("tp5_err", 64'(rsp_err), 64'(1));
`else
        checkOutput("tp5_valid_early", 64'(rsp_valid), 64'(0));
        applyStimulus();
        checkOutput("tp5_valid", 64'(rsp_valid), 64'(3'b010));
        checkOutput("tp5_err", 64'(rsp_err), 64'(0));
`endif
        checkOutput("tp5_data", 64'(rsp_data), 64'(0));
        checkOutput("tp5_zero", 64'(rsp_zero), 64'(1));
        drain();

        // Randomized traffic with random response back-pressure.
        resetDut();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    setReq(i, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                           rnd_val(), rnd_val());
                end
            end
            rdy_vec = N'($urandom);
            applyStimulus();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
